// File: rtl/tri_project_sequencer.sv
// Perspective-projection sequencer: time-multiplexes one shared multiplier over a triangle's x/y.
// Optional macro TRI_PROJECT_SAT_EN saturates projected coordinates instead of truncating them.
module tri_project_sequencer #(
  parameter int COORD_W     = 11,
  parameter int PROD_W      = 24,
  parameter int MUL_LATENCY = 3,
  parameter int FRAC        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COORD_W-1:0]               near_clip,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0][2:0][COORD_W-1:0]     in_tri,
  output logic                             mul_a_valid,
  output logic signed [COORD_W:0]          mul_a,
  output logic signed [COORD_W:0]          mul_b,
  input  logic                             mul_res_valid,
  input  logic signed [PROD_W-1:0]         mul_res,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2:0][2:0][COORD_W-1:0]     out_tri,
  output logic                             busy
);

  localparam int FL_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [2:0] {
    FLUSH  = 3'd0,
    IDLE   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [FL_W-1:0]                 flush_q, flush_d;
  logic [2:0]                      issue_q, issue_d;
  logic [2:0]                      res_cnt_q, res_cnt_d;
  logic [2:0][2:0][COORD_W-1:0]    tri_q;
  logic [COORD_W-1:0]              near_q;
  logic [5:0][COORD_W-1:0]         res_q;

  logic                            hs, cap;
  logic signed [PROD_W:0]          neg_s, shf_s;
  logic [COORD_W-1:0]              res_val;
  logic [7:0][COORD_W-1:0]         ops;

  // Product negation and fixed-point rescale, one extra bit so -(-2^(PROD_W-1)) is representable.
  always_comb begin
    neg_s = -{mul_res[PROD_W-1], mul_res};
    shf_s = neg_s >>> FRAC;
`ifdef TRI_PROJECT_SAT_EN
    if (shf_s > $signed({{(PROD_W+2-COORD_W){1'b0}}, {(COORD_W-1){1'b1}}}))
      res_val = {1'b0, {(COORD_W-1){1'b1}}};
    else if (shf_s < $signed({{(PROD_W+2-COORD_W){1'b1}}, {(COORD_W-1){1'b0}}}))
      res_val = {1'b1, {(COORD_W-1){1'b0}}};
    else
      res_val = COORD_W'(shf_s);
`else
    res_val = COORD_W'(shf_s);
`endif
  end

  // Operand order v0x, v0y, v1x, v1y, v2x, v2y; entries 6/7 never issue.
  always_comb begin
    ops = '0;
    for (int v = 0; v < 3; v++) begin
      ops[2*v]   = tri_q[v][0];
      ops[2*v+1] = tri_q[v][1];
    end
  end

  assign mul_a = {1'b0, ops[issue_q]};
  assign mul_b = {1'b0, near_q};

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    issue_d     = issue_q;
    res_cnt_d   = res_cnt_q;
    in_ready    = 1'b0;
    mul_a_valid = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    hs          = 1'b0;
    cap         = mul_res_valid && (state_q == ISSUE || state_q == DRAIN) && (res_cnt_q != 3'd6);
    if (cap) res_cnt_d = res_cnt_q + 3'd1;
    case (state_q)
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FL_W'(MUL_LATENCY-1)) begin
          state_d = IDLE;
          flush_d = '0;
        end
      end
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          hs        = 1'b1;
          issue_d   = '0;
          res_cnt_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_a_valid = 1'b1;
        issue_d     = issue_q + 3'd1;
        if (issue_q == 3'd5) state_d = DRAIN;
      end
      // Counting the capture of this cycle lets the last result and OUTPUT share one edge.
      DRAIN: if (res_cnt_d == 3'd6) state_d = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FLUSH;
      flush_q   <= '0;
      issue_q   <= '0;
      res_cnt_q <= '0;
      tri_q     <= '0;
      near_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      issue_q   <= issue_d;
      res_cnt_q <= res_cnt_d;
      if (hs) begin
        tri_q  <= in_tri;
        near_q <= near_clip;
      end
      if (cap) res_q[res_cnt_q] <= res_val;
    end
  end

  for (genvar v = 0; v < 3; v++) begin : g_out
    assign out_tri[v][0] = res_q[2*v];
    assign out_tri[v][1] = res_q[2*v+1];
    assign out_tri[v][2] = tri_q[v][2];
  end

endmodule

// File: tb/tb_tri_project_sequencer.sv
// Bench for tri_project_sequencer: directed + random triangles against an arithmetic projection model.
module tb_tri_project_sequencer;
  localparam int CW  = 11;
  localparam int PW  = 24;
  localparam int LAT = 3;

  typedef logic [2:0][2:0][CW-1:0] tri_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CW-1:0]     near_clip = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  tri_t              in_tri = '0;
  logic              mul_a_valid;
  logic [CW:0]       mul_a, mul_b;
  logic              mul_res_valid;
  logic [PW-1:0]     mul_res;
  logic              out_valid;
  logic              out_ready = 1'b1;
  tri_t              out_tri;
  logic              busy;

  int   checks = 0;
  int   failures = 0;
  tri_t last_out;

  // Behavioural multiplier: product appears LAT edges after the operand-sample edge.
  logic          pv [0:LAT] = '{default: 1'b0};
  logic [PW-1:0] pr [0:LAT] = '{default: '0};
  logic          inj = 1'b0;
  logic [PW-1:0] inj_val = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv[0] <= mul_a_valid;
    pr[0] <= PW'($signed(mul_a) * $signed(mul_b));
    for (int i = 1; i <= LAT; i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
    end
  end

  assign mul_res_valid = pv[LAT] | inj;
  assign mul_res       = inj ? inj_val : pr[LAT];

  tri_project_sequencer dut (
    .clk(clk), .rst(rst), .near_clip(near_clip), .in_valid(in_valid), .in_ready(in_ready),
    .in_tri(in_tri), .mul_a_valid(mul_a_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res_valid(mul_res_valid), .mul_res(mul_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_tri(out_tri), .busy(busy)
  );

  function automatic logic [CW-1:0] proj(input logic [CW-1:0] x, input logic [CW-1:0] n);
    longint p, q;
    p = longint'(x) * longint'(n);
    q = (-p) >>> 4;
`ifdef TRI_PROJECT_SAT_EN
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
`endif
    return q[CW-1:0];
  endfunction

  function automatic tri_t exp_tri(input tri_t t, input logic [CW-1:0] n);
    tri_t r;
    for (int v = 0; v < 3; v++) begin
      r[v][0] = proj(t[v][0], n);
      r[v][1] = proj(t[v][1], n);
      r[v][2] = t[v][2];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tri(input tri_t t, input logic [CW-1:0] nc, input int hold,
                        input bit keep_valid, input string tag);
    tri_t             e;
    int               lat, nis, irb, mbb, bpb, w;
    logic [5:0][CW:0] seq, eseq;
    e = exp_tri(t, nc);
    for (int i = 0; i < 6; i++) eseq[i] = {1'b0, t[i/2][i%2]};
    out_ready = (hold == 0);
    in_tri = t; near_clip = nc; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(1));
    step();
    in_valid = keep_valid;
    if (!keep_valid) begin in_tri = ~t; near_clip = ~nc; end
    lat = 0; nis = 0; irb = 0; mbb = 0; seq = '0;
    for (int k = 1; k <= 40; k++) begin
      if (mul_a_valid) begin
        if (nis < 6) seq[nis] = mul_a;
        if (mul_b !== {1'b0, nc}) mbb++;
        nis++;
      end
      if (in_ready) irb++;
      step();
      if (out_valid) begin lat = k; break; end
    end
    last_out = out_tri;
    chk({tag, ".latency"}, 128'(lat), 128'(LAT + 7));
    chk({tag, ".issue_cnt"}, 128'(nis), 128'(6));
    chk({tag, ".mul_a_seq"}, 128'(seq), 128'(eseq));
    chk({tag, ".mul_b_bad"}, 128'(mbb), 128'(0));
    chk({tag, ".in_ready_busy"}, 128'(irb), 128'(0));
    chk({tag, ".out_tri"}, 128'(out_tri), 128'(e));
    bpb = 0;
    for (int h = 0; h < hold; h++) begin
      step();
      if (out_valid !== 1'b1 || out_tri !== e || in_ready !== 1'b0 || mul_a_valid !== 1'b0) bpb++;
    end
    if (hold > 0) chk({tag, ".backpressure"}, 128'(bpb), 128'(0));
    out_ready = 1'b1;
    step();
    chk({tag, ".out_valid_drop"}, 128'(out_valid), 128'(0));
    chk({tag, ".in_ready_after"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    tri_t t;
    tri_t q3 [0:2];
    // Reset state
    #2;
    chk("rst.in_ready", 128'(in_ready), 128'(0));
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    chk("rst.mul_a_valid", 128'(mul_a_valid), 128'(0));
    chk("rst.busy", 128'(busy), 128'(1));
    step(); step();
    rst = 1'b1;
    step(); step();
    chk("flush.in_ready_early", 128'(in_ready), 128'(0));
    step();
    chk("flush.in_ready_done", 128'(in_ready), 128'(1));
    chk("flush.busy_idle", 128'(busy), 128'(0));

    // Basic directed projection
    t = '0;
    t[0][0] = 11'd16;  t[0][1] = 11'd32; t[0][2] = 11'd5;
    t[1][0] = 11'd0;   t[1][1] = 11'd0;  t[1][2] = 11'd7;
    t[2][0] = 11'd160; t[2][1] = 11'd48; t[2][2] = 11'd9;
    do_tri(t, 11'd8, 0, 1'b0, "basic");
    chk("basic.v0", 128'(last_out[0]), 128'({11'd5, 11'h7F0, 11'h7F8}));
    chk("basic.v1", 128'(last_out[1]), 128'({11'd7, 11'h000, 11'h000}));
    chk("basic.v2", 128'(last_out[2]), 128'({11'd9, 11'h7E8, 11'h7B0}));

    // Backpressure for 20 cycles
    do_tri(t, 11'd8, 20, 1'b0, "bp");

    // Reset during DRAIN, stray results during FLUSH
    in_tri = t; near_clip = 11'd8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b0;
    #1;
    chk("mrst.out_valid", 128'(out_valid), 128'(0));
    chk("mrst.in_ready", 128'(in_ready), 128'(0));
    chk("mrst.busy", 128'(busy), 128'(1));
    step();
    rst = 1'b1;
    step();
    inj = 1'b1; inj_val = PW'($urandom);
    chk("mrst.flush1", 128'(in_ready), 128'(0));
    step();
    chk("mrst.flush2", 128'(in_ready), 128'(0));
    step();
    inj = 1'b0;
    chk("mrst.idle", 128'(in_ready), 128'(1));
    t[0][0] = 11'd16;
    do_tri(t, 11'd8, 1, 1'b0, "post_rst");
    chk("post_rst.v0x", 128'(last_out[0][0]), 128'(11'h7F8));

    // Overflow of the 11-bit field
    t[0][0] = 11'd2047;
    do_tri(t, 11'd2047, 0, 1'b0, "ovf");
`ifdef TRI_PROJECT_SAT_EN
    chk("ovf.v0x", 128'(last_out[0][0]), 128'(11'h400));
`else
    chk("ovf.v0x", 128'(last_out[0][0]), 128'(11'h0FF));
`endif

    // Random triangles with random backpressure
    for (int n = 0; n < 6; n++) begin
      for (int v = 0; v < 3; v++)
        for (int c = 0; c < 3; c++) t[v][c] = CW'($urandom_range(0, 2047));
      do_tri(t, CW'($urandom_range(0, 2047)), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 3; v++)
        for (int c = 0; c < 3; c++) q3[i][v][c] = CW'($urandom_range(0, 2047));
    for (int i = 0; i < 3; i++) do_tri(q3[i], 11'd8, 0, (i < 2), "b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
